pwm_fade_ctrl: RTL and testbench
================================

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter CTRVAL, default 256, PWM period in clocks; power of two, 4 to 65536.
REQ-002 SHALL have parameter CTRLEN, default $clog2(CTRVAL), duty and counter width.
REQ-003 SHALL have parameter HOLD_PERIODS, default 16, PWM periods spent in each hold state; range 1 to 255.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  level; starts a fade sequence when sampled high in IDLE.
REQ-007 SHALL have port stop  input  1  level; aborts any sequence.
REQ-008 SHALL have port step  input  CTRLEN  duty increment/decrement per PWM period; 0 is treated as 1.
REQ-009 SHALL have port pwm_counter  input  CTRLEN  counter output of the driven pwm instance.
REQ-010 SHALL have port pwm_enable  output  1  enable to the pwm instance.
REQ-011 SHALL have port duty_cycle  output  CTRLEN  duty to the pwm instance; registered.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at normal sequence completion.

Function
REQ-014 SHALL implement states IDLE, RAMP_UP, HOLD_HI, RAMP_DOWN, HOLD_LO.
REQ-015 SHALL define tick as pwm_enable high and pwm_counter equal to all-ones, i.e. the last cycle of a PWM period.
REQ-016 SHALL, in IDLE with start high and stop low, on the next edge: enter RAMP_UP, drive pwm_enable 1 and duty_cycle 0.
REQ-017 SHALL, in RAMP_UP on tick, set duty_cycle to min(duty_cycle+step, all-ones) using a CTRLEN+1-bit sum with no wrap.
REQ-018 SHALL move RAMP_UP to HOLD_HI on the tick whose update reaches all-ones; the hold counter loads HOLD_PERIODS.
REQ-019 SHALL, in HOLD_HI and HOLD_LO, decrement the hold counter on each tick and leave the state on the tick where the counter reaches 0.
REQ-020 SHALL leave duty_cycle unchanged during hold states.
REQ-021 SHALL move HOLD_HI to RAMP_DOWN.
REQ-022 SHALL, in RAMP_DOWN on tick, set duty_cycle to max(duty_cycle-step, 0) with no underflow.
REQ-023 SHALL enter HOLD_LO on the tick whose update reaches 0.
REQ-024 SHALL update duty_cycle only on tick edges; it is therefore stable for a whole PWM period.
REQ-025 SHALL give stop priority over start and over tick in the same cycle: next edge enters IDLE with duty_cycle 0, pwm_enable 0, and no done pulse.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL, when start is held high in IDLE after done, start a new sequence on the cycle after done.
REQ-028 SHALL treat a step change mid-ramp as effective from the next tick.

Reset
REQ-029 SHALL, on rst high at a clk edge, enter IDLE with duty_cycle 0, pwm_enable 0, busy 0, done 0 and hold counter 0; rst overrides all other inputs.
REQ-030 SHALL, when rst is asserted mid-sequence, abort the sequence with no done pulse.

Configuration
REQ-031 SHALL use macro PWM_FADE_LOOP_EN.
REQ-032 SHALL, when PWM_FADE_LOOP_EN is defined, go from HOLD_LO to RAMP_UP and repeat until stop or rst; done never pulses.
REQ-033 SHALL, when PWM_FADE_LOOP_EN is undefined, go from HOLD_LO to IDLE, pulse done for 1 cycle on the exit edge, and drive pwm_enable 0.

Verification (CTRVAL=16, HOLD_PERIODS=2, macro undefined unless stated)
REQ-034 SHALL cover: reset, then start pulse with step=5 -> duty_cycle 0,5,10,15 on successive ticks; HOLD_HI lasts 2 periods; then 10,5,0; HOLD_LO lasts 2 periods; done is 1 cycle high; busy returns to 0.
REQ-035 SHALL cover: step=0 -> duty increments by 1 per period and reaches 15 after 15 ticks.
REQ-036 SHALL cover: step=7 -> ramp up 7,14,15 (saturates); ramp down 8,1,0 (clamps).
REQ-037 SHALL cover: stop and start both high during RAMP_DOWN on a tick cycle -> IDLE, duty 0, pwm_enable 0, no done.
REQ-038 SHALL cover: rst asserted in HOLD_HI -> all outputs 0 on the next edge; a later start runs a full sequence.
REQ-039 SHALL cover: PWM_FADE_LOOP_EN defined, step=15 -> duty cycles 0,15,hold,0,hold,15 repeatedly with done never high.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - PWM fade sequencer: ramps duty up, holds, ramps down, holds
//
// Drives an external PWM instance through a fade cycle:
//   IDLE -> RAMP_UP -> HOLD_HI -> RAMP_DOWN -> HOLD_LO -> IDLE (or RAMP_UP)
// Duty changes only on the last cycle of a PWM period ("tick"), so each duty
// value is held for a whole period.
//
// Optional feature macro: PWM_FADE_LOOP_EN
//   defined   : HOLD_LO loops back to RAMP_UP until stop/rst; done never pulses
//   undefined : HOLD_LO returns to IDLE with a one-cycle done pulse
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   level; begins a sequence when sampled high in IDLE
//   stop         in   level; aborts any sequence (priority over start and tick)
//   step         in   duty increment/decrement per period (0 treated as 1)
//   pwm_counter  in   counter of the driven PWM instance
//   pwm_enable   out  enable to the PWM instance
//   duty_cycle   out  registered duty to the PWM instance
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse on normal sequence completion

module pwm_fade_ctrl #(
    parameter int CTRVAL       = 256,
    parameter int CTRLEN       = $clog2(CTRVAL),
    parameter int HOLD_PERIODS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [CTRLEN-1:0] step,
    input  logic [CTRLEN-1:0] pwm_counter,
    output logic              pwm_enable,
    output logic [CTRLEN-1:0] duty_cycle,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } state_t;

    localparam logic [CTRLEN-1:0] DUTY_MAX  = '1;
    localparam logic [7:0]        HOLD_LOAD = 8'(HOLD_PERIODS);

    state_t            state_q, state_d;
    logic [CTRLEN-1:0] duty_q, duty_d;
    logic              pwm_enable_q, pwm_enable_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        hold_q, hold_d;

    logic              tick;
    logic [CTRLEN-1:0] step_eff;
    logic [CTRLEN:0]   up_sum;

    always_comb begin
        // Tick is the last cycle of a period of an enabled PWM instance.
        tick     = pwm_enable_q && (pwm_counter == DUTY_MAX);
        step_eff = (step == '0) ? CTRLEN'(1) : step;
        // One extra bit so the ramp-up sum saturates instead of wrapping.
        up_sum   = {1'b0, duty_q} + {1'b0, step_eff};

        state_d      = state_q;
        duty_d       = duty_q;
        pwm_enable_d = pwm_enable_q;
        hold_d       = hold_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RAMP_UP;
                    duty_d       = '0;
                    pwm_enable_d = 1'b1;
                end
            end
            RAMP_UP: begin
                if (tick) begin
                    if (up_sum >= {1'b0, DUTY_MAX}) begin
                        duty_d  = DUTY_MAX;
                        state_d = HOLD_HI;
                        hold_d  = HOLD_LOAD;
                    end else begin
                        duty_d = up_sum[CTRLEN-1:0];
                    end
                end
            end
            HOLD_HI: begin
                if (tick) begin
                    hold_d = hold_q - 8'd1;
                    if (hold_q <= 8'd1) begin
                        state_d = RAMP_DOWN;
                    end
                end
            end
            RAMP_DOWN: begin
                if (tick) begin
                    if (duty_q <= step_eff) begin
                        duty_d  = '0;
                        state_d = HOLD_LO;
                        hold_d  = HOLD_LOAD;
                    end else begin
                        duty_d = duty_q - step_eff;
                    end
                end
            end
            HOLD_LO: begin
                if (tick) begin
                    hold_d = hold_q - 8'd1;
                    if (hold_q <= 8'd1) begin
`ifdef PWM_FADE_LOOP_EN
                        state_d = RAMP_UP;
`else
                        state_d      = IDLE;
                        pwm_enable_d = 1'b0;
                        done_d       = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                duty_d       = '0;
                pwm_enable_d = 1'b0;
                hold_d       = '0;
            end
        endcase

        // Abort overrides every transition above, including a completing tick.
        if (stop) begin
            state_d      = IDLE;
            duty_d       = '0;
            pwm_enable_d = 1'b0;
            hold_d       = '0;
            done_d       = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            duty_q       <= '0;
            pwm_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            pwm_enable_q <= pwm_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hold_q       <= hold_d;
        end
    end

    assign pwm_enable = pwm_enable_q;
    assign duty_cycle = duty_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - self-checking bench for pwm_fade_ctrl (CTRVAL=16, HOLD_PERIODS=2)

module tb_pwm_fade_ctrl;

    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] step = 4'd0;
    logic [3:0] cnt = 4'd0;
    logic       pwm_enable;
    logic [3:0] duty_cycle;
    logic       busy;
    logic       done;

    typedef struct {
        logic [3:0] duty;
        logic       en;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    bit   tick_pend = 1'b0;
    int   tests_run = 0;
    int   failed = 0;
    int   done_seen = 0;

    pwm_fade_ctrl #(.CTRVAL(16), .CTRLEN(4), .HOLD_PERIODS(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
        .pwm_counter(cnt), .pwm_enable(pwm_enable), .duty_cycle(duty_cycle),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Free-running stand-in for the PWM instance's counter.
    always @(posedge clk) cnt <= cnt + 4'd1;

    // After each tick edge, compare the outputs against the next expected entry.
    always @(negedge clk) begin
        if (tick_pend) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_tick: duty=%0d en=%0b busy=%0b done=%0b, required no tick",
                         duty_cycle, pwm_enable, busy, done);
            end else begin
                e = exp_q.pop_front();
                if ({duty_cycle, pwm_enable, busy, done} !== {e.duty, e.en, e.busy, e.done}) begin
                    failed++;
                    $display("FAIL tick_outputs: got duty=%0d en=%0b busy=%0b done=%0b, required duty=%0d en=%0b busy=%0b done=%0b",
                             duty_cycle, pwm_enable, busy, done, e.duty, e.en, e.busy, e.done);
                end
            end
        end
        tick_pend = (pwm_enable === 1'b1) && (cnt == 4'hF);
        if (done === 1'b1) done_seen++;
    end

    task automatic push_exp(input logic [3:0] d, input logic en, input logic b, input logic dn);
        exp_t x;
        x.duty = d; x.en = en; x.busy = b; x.done = dn;
        exp_q.push_back(x);
    endtask

    // Reference model of one complete non-looping sequence, one entry per tick.
    task automatic push_model(input logic [3:0] s_in);
        int s = (s_in == 0) ? 1 : int'(s_in);
        int d = 0;
        while (d != 15) begin
            d = (d + s > 15) ? 15 : d + s;
            push_exp(4'(d), 1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < HOLD; i++) push_exp(4'd15, 1'b1, 1'b1, 1'b0);
        while (d != 0) begin
            d = (d > s) ? d - s : 0;
            push_exp(4'(d), 1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < HOLD - 1; i++) push_exp(4'd0, 1'b1, 1'b1, 1'b0);
        push_exp(4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) exp_q.delete();
    endtask

    task automatic pulse_start(input bit hold_high);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold_high) start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; step = 4'd5;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({duty_cycle, pwm_enable, busy, done} !== 7'b0) begin
            failed++;
            $display("FAIL reset_outputs: got duty=%0d en=%0b busy=%0b done=%0b, required all 0",
                     duty_cycle, pwm_enable, busy, done);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL idle_after_reset: busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_fade_step5;
        bit ok;
        int d0 = done_seen;
        step = 4'd5;
        push_model(4'd5);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({duty_cycle, pwm_enable, busy} !== {4'd0, 1'b1, 1'b1}) begin
            failed++;
            $display("FAIL start_entry: got duty=%0d en=%0b busy=%0b, required duty=0 en=1 busy=1",
                     duty_cycle, pwm_enable, busy);
        end
        wait_drain(2000, ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL step5_timeout: sequence incomplete, required completion within 2000 cycles");
        end
        @(negedge clk);
        tests_run++;
        if ({done, busy, pwm_enable} !== 3'b000) begin
            failed++;
            $display("FAIL done_one_cycle: got done=%0b busy=%0b en=%0b, required 0 0 0", done, busy, pwm_enable);
        end
        tests_run++;
        if (done_seen - d0 !== 1) begin
            failed++;
            $display("FAIL done_count_step5: got %0d pulses, required 1", done_seen - d0);
        end
    endtask

    task automatic test_step_zero;
        bit ok;
        step = 4'd0;
        push_model(4'd0);
        pulse_start(1'b0);
        wait_drain(2000, ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL step0_timeout: sequence incomplete, required completion");
        end
        @(negedge clk);
    endtask

    task automatic test_step_saturate;
        bit ok;
        step = 4'd7;
        push_model(4'd7);
        pulse_start(1'b0);
        wait_drain(2000, ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL step7_timeout: sequence incomplete, required completion");
        end
        @(negedge clk);
    endtask

    task automatic test_stop_priority;
        bit ok;
        bit hit = 1'b0;
        int d0 = done_seen;
        step = 4'd5;
        push_model(4'd5);
        while (exp_q.size() > 6) void'(exp_q.pop_back());
        pulse_start(1'b0);
        wait_drain(2000, ok);
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (pwm_enable === 1'b1 && cnt == 4'hF) hit = 1'b1;
        end
        tests_run++;
        if (!(ok && hit)) begin
            failed++;
            $display("FAIL stop_setup: reached_ramp_down=%0b tick_found=%0b, required 1 1", ok, hit);
        end
        push_exp(4'd0, 1'b0, 1'b0, 1'b0);
        stop = 1'b1; start = 1'b1;
        @(negedge clk);
        #1;
        stop = 1'b0; start = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, pwm_enable, duty_cycle} !== {1'b0, 1'b0, 4'd0}) begin
            failed++;
            $display("FAIL stop_idle: got busy=%0b en=%0b duty=%0d, required 0 0 0", busy, pwm_enable, duty_cycle);
        end
        tests_run++;
        if (done_seen !== d0) begin
            failed++;
            $display("FAIL stop_no_done: got %0d done pulses, required 0", done_seen - d0);
        end
    endtask

    task automatic test_reset_mid_hold;
        bit ok;
        int d0;
        step = 4'd5;
        push_model(4'd5);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        pulse_start(1'b0);
        wait_drain(2000, ok);
        d0 = done_seen;
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if ({duty_cycle, pwm_enable, busy, done} !== 7'b0 || !ok) begin
            failed++;
            $display("FAIL rst_in_hold: got duty=%0d en=%0b busy=%0b done=%0b reached_hold=%0b, required all 0 and 1",
                     duty_cycle, pwm_enable, busy, done, ok);
        end
        rst = 1'b0; start = 1'b0;
        push_model(4'd5);
        pulse_start(1'b0);
        wait_drain(2000, ok);
        @(negedge clk);
        tests_run++;
        if (!ok || done_seen - d0 !== 1) begin
            failed++;
            $display("FAIL rerun_after_rst: completed=%0b done_pulses=%0d, required 1 and 1", ok, done_seen - d0);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        step = 4'd15;
        push_model(4'd15);
        pulse_start(1'b1);
        wait_drain(2000, ok);
        @(negedge clk);
        tests_run++;
        if (!ok || {busy, pwm_enable, duty_cycle} !== {1'b1, 1'b1, 4'd0}) begin
            failed++;
            $display("FAIL back_to_back_restart: completed=%0b busy=%0b en=%0b duty=%0d, required 1 1 1 0",
                     ok, busy, pwm_enable, duty_cycle);
        end
        stop = 1'b1; start = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        tests_run++;
        if ({busy, pwm_enable} !== 2'b00) begin
            failed++;
            $display("FAIL back_to_back_stop: busy=%0b en=%0b, required 0 0", busy, pwm_enable);
        end
    endtask

    task automatic test_loop;
        bit ok;
        int d0 = done_seen;
        step = 4'd15;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < HOLD + 1; i++) push_exp(4'd15, 1'b1, 1'b1, 1'b0);
            for (int i = 0; i < HOLD + 1; i++) push_exp(4'd0, 1'b1, 1'b1, 1'b0);
        end
        push_exp(4'd15, 1'b1, 1'b1, 1'b0);
        pulse_start(1'b0);
        wait_drain(2000, ok);
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL loop_timeout: loop sequence incomplete, required completion");
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        tests_run++;
        if (done_seen !== d0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL loop_no_done: done_pulses=%0d busy=%0b, required 0 and 0", done_seen - d0, busy);
        end
    endtask

    initial begin
        test_reset;
`ifdef PWM_FADE_LOOP_EN
        test_loop;
`else
        test_fade_step5;
        test_step_zero;
        test_step_saturate;
        test_stop_priority;
        test_reset_mid_hold;
        test_back_to_back;
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
